// File: rtl/mem_access.sv
// mem_access: load/store unit between a pipeline request port and a
// single-ported word memory. Sub-word stores are done read-modify-write.
// Optional feature macro: MEM_ACCESS_MISALIGN_TRAP_EN
//   defined   -> misaligned accesses skip memory and respond with resp_err=1
//   undefined -> misaligned addresses are forced to alignment, resp_err=0
//
// state | meaning
// IDLE  | waiting for a request (req_ready=1)
// READ  | mem_rd asserted, word captured at the end of the cycle
// WRITE | mem_wr asserted for one cycle
// RESP  | resp_valid held until resp_ready
module mem_access #(
  parameter int ADDR_W = 7
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [1:0]        req_size,
  input  logic              req_sign,
  input  logic [ADDR_W+1:0] req_addr,
  input  logic [31:0]       req_wdata,
  output logic              resp_valid,
  input  logic              resp_ready,
  output logic [31:0]       resp_rdata,
  output logic              resp_err,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_rd,
  output logic              mem_wr,
  output logic [31:0]       mem_wdata,
  input  logic [31:0]       mem_rdata
);

  typedef enum logic [1:0] {IDLE, READ, WRITE, RESP} state_t;

  state_t            state;
  logic              we_r;
  logic              sign_r;
  logic [1:0]        size_r;
  logic [ADDR_W+1:0] addr_r;
  logic [31:0]       wdata_r;
  logic [31:0]       rdata_r;
  logic [31:0]       wdata_out_r;

  logic [ADDR_W+1:0] addr_aligned;
  logic [4:0]        lane_sh;
  logic [31:0]       shifted;
  logic [31:0]       load_val;
  logic [31:0]       merged;
  logic [31:0]       lane_mask;

  assign req_ready  = (state == IDLE);
  assign resp_valid = (state == RESP);
  assign mem_rd     = (state == READ);
  assign mem_wr     = (state == WRITE);
  assign mem_addr   = addr_r[ADDR_W+1:2];
  assign mem_wdata  = wdata_out_r;
  assign resp_rdata = rdata_r;

  // Force the incoming byte address to the natural alignment of its size.
  always_comb begin
    addr_aligned = req_addr;
    if (req_size == 2'b01)
      addr_aligned[0] = 1'b0;
    else if (req_size[1])
      addr_aligned[1:0] = 2'b00;
  end

  // Lane extraction for loads and lane merge for sub-word stores.
  always_comb begin
    lane_sh = {addr_r[1:0], 3'b000};
    shifted = mem_rdata >> lane_sh;
    case (size_r)
      2'b00: begin
        load_val  = {{24{sign_r & shifted[7]}}, shifted[7:0]};
        lane_mask = 32'h0000_00FF << lane_sh;
      end
      2'b01: begin
        load_val  = {{16{sign_r & shifted[15]}}, shifted[15:0]};
        lane_mask = 32'h0000_FFFF << lane_sh;
      end
      default: begin
        load_val  = mem_rdata;
        lane_mask = 32'hFFFF_FFFF;
      end
    endcase
    merged = (mem_rdata & ~lane_mask) | ((wdata_r << lane_sh) & lane_mask);
  end

`ifdef MEM_ACCESS_MISALIGN_TRAP_EN
  logic err_r;
  logic misaligned;
  assign resp_err   = err_r;
  assign misaligned = ((req_size == 2'b01) && req_addr[0]) ||
                      (req_size[1] && (req_addr[1:0] != 2'b00));
`else
  assign resp_err = 1'b0;
`endif

  // Access sequencer: request capture, memory strobes and response hold.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      we_r        <= 1'b0;
      sign_r      <= 1'b0;
      size_r      <= 2'b00;
      addr_r      <= '0;
      wdata_r     <= '0;
      rdata_r     <= '0;
      wdata_out_r <= '0;
`ifdef MEM_ACCESS_MISALIGN_TRAP_EN
      err_r       <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (req_valid) begin
            we_r    <= req_we;
            sign_r  <= req_sign;
            size_r  <= req_size;
            addr_r  <= addr_aligned;
            wdata_r <= req_wdata;
            rdata_r <= '0;
`ifdef MEM_ACCESS_MISALIGN_TRAP_EN
            err_r   <= misaligned;
            if (misaligned)
              state <= RESP;
            else
`endif
            if (req_we && req_size[1]) begin
              wdata_out_r <= req_wdata;
              state       <= WRITE;
            end else begin
              state <= READ;
            end
          end
        end
        READ: begin
          if (we_r) begin
            wdata_out_r <= merged;
            state       <= WRITE;
          end else begin
            rdata_r <= load_val;
            state   <= RESP;
          end
        end
        WRITE: state <= RESP;
        RESP: if (resp_ready) state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_access.sv
// tb_mem_access: directed bench for mem_access with a behavioural word memory.
module tb_mem_access;

  localparam int ADDR_W = 7;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              req_valid = 1'b0;
  logic              req_ready;
  logic              req_we = 1'b0;
  logic [1:0]        req_size = 2'b00;
  logic              req_sign = 1'b0;
  logic [ADDR_W+1:0] req_addr = '0;
  logic [31:0]       req_wdata = '0;
  logic              resp_valid;
  logic              resp_ready = 1'b1;
  logic [31:0]       resp_rdata;
  logic              resp_err;
  logic [ADDR_W-1:0] mem_addr;
  logic              mem_rd;
  logic              mem_wr;
  logic [31:0]       mem_wdata;
  logic [31:0]       mem_rdata;

  logic [31:0]       mem [0:(1<<ADDR_W)-1];
  logic              pre_we = 1'b0;
  logic [ADDR_W-1:0] pre_addr = '0;
  logic [31:0]       pre_data = '0;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  mem_access #(.ADDR_W(ADDR_W)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_size(req_size), .req_sign(req_sign), .req_addr(req_addr),
    .req_wdata(req_wdata),
    .resp_valid(resp_valid), .resp_ready(resp_ready),
    .resp_rdata(resp_rdata), .resp_err(resp_err),
    .mem_addr(mem_addr), .mem_rd(mem_rd), .mem_wr(mem_wr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );

  assign mem_rdata = mem[mem_addr];

  // Memory model: DUT writes, or a bench preload when the DUT is not writing.
  always @(posedge clk) begin
    if (mem_wr)
      mem[mem_addr] <= mem_wdata;
    else if (pre_we)
      mem[pre_addr] <= pre_data;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic preload(input logic [ADDR_W-1:0] a, input logic [31:0] d);
    @(negedge clk);
    pre_we = 1'b1; pre_addr = a; pre_data = d;
    @(negedge clk);
    pre_we = 1'b0;
  endtask

  // One transaction with resp_ready held high. Cycle 1 is the cycle after
  // the acceptance edge; lat is the cycle in which resp_valid is first seen.
  task automatic txn(input logic we, input logic [1:0] size, input logic sign,
                     input logic [ADDR_W+1:0] addr, input logic [31:0] wdata,
                     output logic [31:0] rd, output logic er,
                     output int lat, output int wrn, output int wrc, output int rdn);
    int c;
    wrn = 0; wrc = 0; rdn = 0; lat = 0; rd = 'x; er = 1'bx;
    @(negedge clk);
    resp_ready = 1'b1;
    req_valid = 1'b1; req_we = we; req_size = size; req_sign = sign;
    req_addr = addr; req_wdata = wdata;
    check("req_ready_before_accept", {31'd0, req_ready}, 32'd1);
    @(posedge clk);
    #1 req_valid = 1'b0;
    for (c = 1; c <= 10; c++) begin
      if (mem_wr) begin wrn++; wrc = c; end
      if (mem_rd) rdn++;
      if (resp_valid) begin
        lat = c; rd = resp_rdata; er = resp_err;
        break;
      end
      @(posedge clk); #1;
    end
    @(posedge clk); #1;
  endtask

  logic [31:0] rd;
  logic        er;
  int          lat, wrn, wrc, rdn;
  logic [31:0] held;

  initial begin
    // Reset state
    #12;
    check("rst_req_ready",  {31'd0, req_ready},  32'd1);
    check("rst_resp_valid", {31'd0, resp_valid}, 32'd0);
    check("rst_resp_err",   {31'd0, resp_err},   32'd0);
    check("rst_mem_rd",     {31'd0, mem_rd},     32'd0);
    check("rst_mem_wr",     {31'd0, mem_wr},     32'd0);
    check("rst_resp_rdata", resp_rdata,          32'd0);
    check("rst_mem_wdata",  mem_wdata,           32'd0);
    check("rst_mem_addr",   {25'd0, mem_addr},   32'd0);
    @(negedge clk); rst_n = 1'b1;
    preload(7'd4, 32'h0000_0000);

    // Word store then word load
    txn(1'b1, 2'b10, 1'b0, 9'h010, 32'hDEAD_BEEF, rd, er, lat, wrn, wrc, rdn);
    check("sw_latency", lat, 2);
    check("sw_wr_pulses", wrn, 1);
    check("sw_wr_cycle", wrc, 1);
    check("sw_rd_pulses", rdn, 0);
    check("sw_rdata_zero", rd, 32'd0);
    check("sw_mem", mem[4], 32'hDEAD_BEEF);
    txn(1'b0, 2'b10, 1'b0, 9'h010, 32'd0, rd, er, lat, wrn, wrc, rdn);
    check("lw_latency", lat, 2);
    check("lw_rdata", rd, 32'hDEAD_BEEF);
    check("lw_wr_pulses", wrn, 0);

    // Byte store (read-modify-write)
    txn(1'b1, 2'b00, 1'b0, 9'h011, 32'h0000_0055, rd, er, lat, wrn, wrc, rdn);
    check("sb_latency", lat, 3);
    check("sb_wr_pulses", wrn, 1);
    check("sb_wr_cycle", wrc, 2);
    check("sb_rd_pulses", rdn, 1);
    txn(1'b0, 2'b10, 1'b0, 9'h010, 32'd0, rd, er, lat, wrn, wrc, rdn);
    check("sb_readback", rd, 32'hDEAD_55EF);

    // Sub-word loads with sign/zero extension
    preload(7'd4, 32'h80F0_7F01);
    txn(1'b0, 2'b00, 1'b1, 9'h011, 32'd0, rd, er, lat, wrn, wrc, rdn);
    check("lb_011_signed", rd, 32'h0000_007F);
    check("lb_latency", lat, 2);
    txn(1'b0, 2'b00, 1'b1, 9'h013, 32'd0, rd, er, lat, wrn, wrc, rdn);
    check("lb_013_signed", rd, 32'hFFFF_FF80);
    txn(1'b0, 2'b00, 1'b0, 9'h013, 32'd0, rd, er, lat, wrn, wrc, rdn);
    check("lbu_013", rd, 32'h0000_0080);
    txn(1'b0, 2'b01, 1'b0, 9'h012, 32'd0, rd, er, lat, wrn, wrc, rdn);
    check("lhu_012", rd, 32'h0000_80F0);
    txn(1'b0, 2'b01, 1'b1, 9'h012, 32'd0, rd, er, lat, wrn, wrc, rdn);
    check("lh_012_signed", rd, 32'hFFFF_80F0);
    txn(1'b0, 2'b01, 1'b0, 9'h010, 32'd0, rd, er, lat, wrn, wrc, rdn);
    check("lhu_010", rd, 32'h0000_7F01);

    // Misaligned halfword load
    txn(1'b0, 2'b01, 1'b0, 9'h013, 32'd0, rd, er, lat, wrn, wrc, rdn);
`ifdef MEM_ACCESS_MISALIGN_TRAP_EN
    check("mis_err", {31'd0, er}, 32'd1);
    check("mis_rdata", rd, 32'd0);
    check("mis_rd_pulses", rdn, 0);
    check("mis_latency", lat, 1);
`else
    check("mis_err", {31'd0, er}, 32'd0);
    check("mis_rdata", rd, 32'h0000_80F0);
    check("mis_rd_pulses", rdn, 1);
    check("mis_latency", lat, 2);
`endif

    // Halfword store into the upper lane
    txn(1'b1, 2'b01, 1'b0, 9'h012, 32'h1234_ABCD, rd, er, lat, wrn, wrc, rdn);
    check("sh_latency", lat, 3);
    check("sh_wr_pulses", wrn, 1);
    check("sh_mem", mem[4], 32'hABCD_7F01);

    // Response back-pressure
    @(negedge clk);
    resp_ready = 1'b0;
    req_valid = 1'b1; req_we = 1'b0; req_size = 2'b10; req_sign = 1'b0;
    req_addr = 9'h010;
    @(posedge clk); #1 req_valid = 1'b0;
    @(posedge clk); #1;
    check("stall_first_valid", {31'd0, resp_valid}, 32'd1);
    held = resp_rdata;
    check("stall_rdata", held, 32'hABCD_7F01);
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      check("stall_valid_held", {31'd0, resp_valid}, 32'd1);
      check("stall_rdata_held", resp_rdata, 32'hABCD_7F01);
      check("stall_req_ready", {31'd0, req_ready}, 32'd0);
    end
    @(negedge clk); resp_ready = 1'b1;
    @(posedge clk); #1;
    check("release_valid", {31'd0, resp_valid}, 32'd0);
    check("release_req_ready", {31'd0, req_ready}, 32'd1);

    // Reset during the WRITE cycle of a byte store
    @(negedge clk);
    req_valid = 1'b1; req_we = 1'b1; req_size = 2'b00; req_sign = 1'b0;
    req_addr = 9'h010; req_wdata = 32'h0000_0099;
    @(posedge clk); #1 req_valid = 1'b0;
    @(posedge clk); #1;
    check("abort_in_write", {31'd0, mem_wr}, 32'd1);
    #2 rst_n = 1'b0;
    #1;
    check("abort_mem_wr_async", {31'd0, mem_wr}, 32'd0);
    check("abort_resp_valid", {31'd0, resp_valid}, 32'd0);
    check("abort_req_ready", {31'd0, req_ready}, 32'd1);
    @(posedge clk); @(posedge clk); #1;
    check("abort_mem_unchanged", mem[4], 32'hABCD_7F01);
    check("abort_no_resp", {31'd0, resp_valid}, 32'd0);
    @(negedge clk); rst_n = 1'b1;
    txn(1'b0, 2'b10, 1'b0, 9'h010, 32'd0, rd, er, lat, wrn, wrc, rdn);
    check("post_reset_lw", rd, 32'hABCD_7F01);
    check("post_reset_latency", lat, 2);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/mem_access.md
MEM_ACCESS -- requirements
Module: mem_access

Interface
REQ-001 The block SHALL have parameter ADDR_W, default 7, giving the word-address width presented to the data memory.
REQ-002 The block SHALL have port clk, input, 1 bit: single clock; all state updates on its rising edge.
REQ-003 The block SHALL have port rst_n, input, 1 bit: reset, asynchronous, active-low.
REQ-004 The block SHALL have port req_valid, input, 1 bit: pipeline request present.
REQ-005 The block SHALL have port req_ready, output, 1 bit: block can accept a request.
REQ-006 The block SHALL have port req_we, input, 1 bit: 1 = store, 0 = load.
REQ-007 The block SHALL have port req_size, input, 2 bits: 00 byte, 01 halfword, 10 word; 11 is treated as word.
REQ-008 The block SHALL have port req_sign, input, 1 bit: 1 = sign-extend sub-word loads, 0 = zero-extend.
REQ-009 The block SHALL have port req_addr, input, ADDR_W+2 bits: byte address.
REQ-010 The block SHALL have port req_wdata, input, 32 bits: store data, right-aligned.
REQ-011 The block SHALL have port resp_valid, output, 1 bit: response present.
REQ-012 The block SHALL have port resp_ready, input, 1 bit: consumer accepts the response.
REQ-013 The block SHALL have port resp_rdata, output, 32 bits: load result; 0 for stores.
REQ-014 The block SHALL have port resp_err, output, 1 bit: misaligned access flag.
REQ-015 The block SHALL have port mem_addr, output, ADDR_W bits: word address to the data memory.
REQ-016 The block SHALL have ports mem_rd and mem_wr, outputs, 1 bit each: memory read and write strobes.
REQ-017 The block SHALL have port mem_wdata, output, 32 bits: full-word write data.
REQ-018 The block SHALL have port mem_rdata, input, 32 bits: combinational read data from the memory.

Function
REQ-019 The FSM SHALL have exactly four states: IDLE, READ, WRITE and RESP; req_ready SHALL be 1 only in IDLE.
REQ-020 A request SHALL be accepted when req_valid and req_ready are both 1; on acceptance all req_* fields SHALL be registered.
REQ-021 On acceptance, the next state SHALL be READ for a load or a sub-word store, WRITE for a word store, and RESP for a misaligned access.
REQ-022 In READ, mem_rd=1 and mem_addr=addr[ADDR_W+1:2]; mem_rdata SHALL be captured at the end of READ; the next state SHALL be WRITE for a store, otherwise RESP.
REQ-023 In WRITE, mem_wr SHALL be 1 for exactly one cycle.
REQ-024 For a word store in WRITE, mem_wdata SHALL equal req_wdata.
REQ-025 For a sub-word store in WRITE, mem_wdata SHALL be the captured word with the addressed lane(s) replaced; the byte lane is selected by addr[1:0] and the halfword lane by addr[1] (little-endian).
REQ-026 WRITE SHALL always be followed by RESP.
REQ-027 In RESP, resp_valid SHALL be 1 and held, with stable resp_rdata and resp_err, until resp_ready=1; the FSM SHALL then return to IDLE.
REQ-028 A load response SHALL carry the addressed byte, halfword or word, right-aligned and extended per req_sign.
REQ-029 Latency from acceptance to first resp_valid SHALL be: load 2 cycles, word store 2 cycles, sub-word store 3 cycles.
REQ-030 An access is misaligned when it is a halfword with addr[0]=1, or a word with addr[1:0]!=00.
REQ-031 mem_rd and mem_wr SHALL never be asserted together and SHALL be 0 outside READ and WRITE respectively.
REQ-032 A new request SHALL not be accepted in the same cycle that a response is consumed; back-to-back throughput is one request per 3-4 cycles.

Reset
REQ-033 While rst_n=0, the FSM SHALL be IDLE and req_ready=1, and resp_valid, resp_err, mem_rd and mem_wr SHALL be 0; resp_rdata, mem_wdata and mem_addr SHALL be 0.
REQ-034 Reset asserted mid-operation SHALL abort the operation immediately (asynchronously), suppressing any pending mem_wr, and SHALL produce no response.

Configuration
REQ-035 With MEM_ACCESS_MISALIGN_TRAP_EN defined, a misaligned access SHALL make no memory access and SHALL respond with resp_err=1 and resp_rdata=0.
REQ-036 With MEM_ACCESS_MISALIGN_TRAP_EN undefined, the low address bits SHALL be forced to alignment (halfword clears addr[0], word clears addr[1:0]), the access SHALL proceed normally, and resp_err SHALL be tied to 0.

Verification
REQ-037 Verification SHALL cover: word store 0xDEADBEEF to byte address 0x010, then word load from 0x010 -> resp_rdata=0xDEADBEEF; resp_valid appears 2 cycles after acceptance for each request.
REQ-038 Verification SHALL cover: after REQ-037, byte store 0x55 to 0x011, then word load 0x010 -> 0xDEAD55EF; exactly one mem_wr pulse, 2 cycles after acceptance.
REQ-039 Verification SHALL cover: memory word 0x80F07F01 at word address 4; byte loads from 0x011 signed -> 0x0000007F, from 0x013 signed -> 0xFFFFFF80, and halfword load from 0x012 unsigned -> 0x000080F0.
REQ-040 Verification SHALL cover: halfword load from 0x013 with MEM_ACCESS_MISALIGN_TRAP_EN defined -> resp_err=1, resp_rdata=0, mem_rd never asserted; with the macro undefined -> data from address 0x012 and resp_err=0.
REQ-041 Verification SHALL cover: holding resp_ready=0 for 5 cycles -> resp_valid and resp_rdata stay stable and req_ready stays 0; releasing resp_ready -> return to IDLE on the next cycle.
REQ-042 Verification SHALL cover: rst_n driven low during the WRITE cycle of a byte store -> mem_wr drops without waiting for a clock edge, memory is unchanged, no resp_valid, and req_ready=1.
